// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and priority helper for the register-file writeback arbiter.
// The init sweep is enabled by defining REGFILE_INIT_SWEEP_EN.
package regfile_pkg;

   localparam int RF_ADDR_W   = 6;
   localparam int RF_DATA_W   = 128;
   localparam int RF_SCALAR_W = 32;
   localparam int RF_NUM_REGS = 25;
   localparam int RF_VEC_BIT  = 5;
   localparam int RF_LAST_IDX = 24;

   typedef enum logic {SWEEP, ARB} state_e;

   // Position of the lowest set bit of a request vector already rotated so bit 0 is the pointer.
   function automatic logic [2:0] first_valid(input logic [7:0] rot);
      logic [2:0] pos;
      pos = '0;
      for (int i = 7; i >= 0; i--) begin
         if (rot[i]) pos = i[2:0];
      end
      return pos;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [2:0]         gnt_idx
);

   localparam logic [3:0] NUM_REQ_W = 4'(NUM_REQ);

   logic [2*NUM_REQ-1:0] req_rot;
   logic [7:0]           rot;
   logic [3:0]           sum;

   // Rotating a doubled copy puts requester ptr at bit 0 without a modulo per bit.
   always_comb begin
      req_rot = {req, req} >> ptr;
      rot     = '0;
      rot[NUM_REQ-1:0] = req_rot[NUM_REQ-1:0];
      sum = {1'b0, ptr} + {1'b0, first_valid(rot)};
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      gnt_idx = sum[2:0];
      gnt     = '0;
      if (|req) gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between writeback requesters with round-robin arbitration.
// Defining REGFILE_INIT_SWEEP_EN adds a post-reset sweep that zeroes all 50 registers first.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*RF_ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*RF_DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           rf_we,
   output logic [RF_ADDR_W-1:0]           rf_addr,
   output logic [RF_DATA_W-1:0]           rf_wd,
   output logic [2:0]                     grant_id,
   output logic                           init_done,
   output logic                           addr_err
);

   localparam logic [4:0] LAST_IDX = 5'(RF_LAST_IDX);
   localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);

   state_e                 state_q, state_d;
   logic [2:0]             ptr_q, ptr_d;
   logic                   rf_we_q, rf_we_d;
   logic [RF_ADDR_W-1:0]   rf_addr_q, rf_addr_d;
   logic [RF_DATA_W-1:0]   rf_wd_q, rf_wd_d;
   logic [2:0]             grant_id_q, grant_id_d;
   logic                   init_done_q, init_done_d;
   logic                   addr_err_q, addr_err_d;

   logic [NUM_REQ-1:0]     gnt;
   logic [2:0]             gnt_idx;
   logic [RF_ADDR_W-1:0]   sel_addr;
   logic [RF_DATA_W-1:0]   sel_data;
   logic [4:0]             sel_idx;

`ifdef REGFILE_INIT_SWEEP_EN
   localparam logic [5:0] SWEEP_WRITES = 6'(2 * RF_NUM_REGS);
   localparam logic [5:0] SCALAR_REGS  = 6'(RF_NUM_REGS);
   localparam logic [5:0] VEC_SKIP     = 6'((1 << RF_VEC_BIT) - RF_NUM_REGS);
   logic [5:0]             sweep_cnt_q, sweep_cnt_d;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
            sel_data = req_data[i*RF_DATA_W +: RF_DATA_W];
         end
      end
      sel_idx   = sel_addr[4:0];
      req_ready = init_done_q ? gnt : '0;
   end

   // Register 0 is only ever written by the sweep; out-of-range indices are swallowed and flagged.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rf_we_d     = 1'b0;
      rf_addr_d   = rf_addr_q;
      rf_wd_d     = rf_wd_q;
      grant_id_d  = grant_id_q;
      init_done_d = init_done_q;
      addr_err_d  = addr_err_q;
`ifdef REGFILE_INIT_SWEEP_EN
      sweep_cnt_d = sweep_cnt_q;
`endif
      case (state_q)
`ifdef REGFILE_INIT_SWEEP_EN
         SWEEP: begin
            if (sweep_cnt_q < SWEEP_WRITES) begin
               rf_we_d     = 1'b1;
               rf_addr_d   = (sweep_cnt_q < SCALAR_REGS) ? sweep_cnt_q : sweep_cnt_q + VEC_SKIP;
               rf_wd_d     = '0;
               sweep_cnt_d = sweep_cnt_q + 6'd1;
            end else begin
               state_d     = ARB;
               init_done_d = 1'b1;
            end
         end
`endif
         ARB: begin
            init_done_d = 1'b1;
            if (|req_ready) begin
               grant_id_d = gnt_idx;
               ptr_d      = (gnt_idx == LAST_REQ) ? 3'd0 : gnt_idx + 3'd1;
               if (sel_idx > LAST_IDX) begin
                  addr_err_d = 1'b1;
               end else if (sel_idx != 5'd0) begin
                  rf_we_d   = 1'b1;
                  rf_addr_d = sel_addr;
                  rf_wd_d   = sel_addr[RF_VEC_BIT] ? sel_data :
                              {{(RF_DATA_W-RF_SCALAR_W){1'b0}}, sel_data[RF_SCALAR_W-1:0]};
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
`ifdef REGFILE_INIT_SWEEP_EN
         state_q     <= SWEEP;
         sweep_cnt_q <= '0;
`else
         state_q     <= ARB;
`endif
         ptr_q       <= '0;
         rf_we_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_wd_q     <= '0;
         grant_id_q  <= '0;
         init_done_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
`ifdef REGFILE_INIT_SWEEP_EN
         sweep_cnt_q <= sweep_cnt_d;
`endif
         ptr_q       <= ptr_d;
         rf_we_q     <= rf_we_d;
         rf_addr_q   <= rf_addr_d;
         rf_wd_q     <= rf_wd_d;
         grant_id_q  <= grant_id_d;
         init_done_q <= init_done_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_wd     = rf_wd_q;
   assign grant_id  = grant_id_q;
   assign init_done = init_done_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a cycle model checked every cycle plus directed literal checks.
// Follows REGFILE_INIT_SWEEP_EN the same way the design does.
module tb_regfile_wb_arbiter;

   localparam int NUM_REQ = 3;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ*6-1:0]  req_addr = '0;
   logic [NUM_REQ*128-1:0] req_data = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rf_we;
   logic [5:0]            rf_addr;
   logic [127:0]          rf_wd;
   logic [2:0]            grant_id;
   logic                  init_done;
   logic                  addr_err;

   int vectors = 0;
   int miscompares = 0;

   regfile_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wd     (rf_wd),
      .grant_id  (grant_id),
      .init_done (init_done),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what the register-file port must show after the most recent edge.
   logic          m_init = 1'b0;
   int            m_sweep = 0;
   int            m_ptr = 0;
   logic          m_we = 1'b0;
   logic [5:0]    m_addr = '0;
   logic [127:0]  m_wd = '0;
   logic [2:0]    m_gid = '0;
   logic          m_err = 1'b0;

   int            exp_gnt;
   logic [5:0]    g_addr;
   logic [127:0]  g_data;

   function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         int i = (p + k) % NUM_REQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [5:0] sweep_addr(input int n);
      return (n < 25) ? 6'(n) : 6'(32 + n - 25);
   endfunction

   always_comb begin
      exp_gnt = model_grant(req_valid, m_ptr);
      g_addr  = '0;
      g_data  = '0;
      if (exp_gnt >= 0) begin
         g_addr = req_addr[6*exp_gnt +: 6];
         g_data = req_data[128*exp_gnt +: 128];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_init <= 1'b0; m_sweep <= 0; m_ptr <= 0; m_we <= 1'b0;
         m_addr <= '0; m_wd <= '0; m_gid <= '0; m_err <= 1'b0;
      end else if (!m_init) begin
`ifdef REGFILE_INIT_SWEEP_EN
         if (m_sweep < 50) begin
            m_we    <= 1'b1;
            m_addr  <= sweep_addr(m_sweep);
            m_wd    <= '0;
            m_sweep <= m_sweep + 1;
         end else begin
            m_we   <= 1'b0;
            m_init <= 1'b1;
         end
`else
         m_we   <= 1'b0;
         m_init <= 1'b1;
`endif
      end else if (exp_gnt >= 0) begin
         m_gid <= 3'(exp_gnt);
         m_ptr <= (exp_gnt + 1) % NUM_REQ;
         if (g_addr[4:0] == 5'd0) begin
            m_we <= 1'b0;
         end else if (g_addr[4:0] > 5'd24) begin
            m_we  <= 1'b0;
            m_err <= 1'b1;
         end else begin
            m_we   <= 1'b1;
            m_addr <= g_addr;
            m_wd   <= g_addr[5] ? g_data : {96'h0, g_data[31:0]};
         end
      end else begin
         m_we <= 1'b0;
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      logic [NUM_REQ-1:0] exp_rdy;
      #2;
      exp_rdy = '0;
      if (rst) begin
         checkOutput("rst_rf_we", rf_we, 0);
         checkOutput("rst_rf_addr", rf_addr, 0);
         checkOutput("rst_rf_wd", rf_wd, 0);
         checkOutput("rst_grant_id", grant_id, 0);
         checkOutput("rst_init_done", init_done, 0);
         checkOutput("rst_addr_err", addr_err, 0);
         checkOutput("rst_req_ready", req_ready, 0);
      end else begin
         if (m_init && exp_gnt >= 0) exp_rdy = NUM_REQ'(1) << exp_gnt;
         checkOutput("req_ready", req_ready, exp_rdy);
         checkOutput("rf_we", rf_we, m_we);
         if (m_we) begin
            checkOutput("rf_addr", rf_addr, m_addr);
            checkOutput("rf_wd", rf_wd, m_wd);
         end
         checkOutput("grant_id", grant_id, m_gid);
         checkOutput("init_done", init_done, m_init);
         checkOutput("addr_err", addr_err, m_err);
      end
   end

   task automatic applyStimulus(input logic [2:0] v,
                                input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                                input logic [127:0] d0, input logic [127:0] d1, input logic [127:0] d2);
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
   endtask

   task automatic idle();
      applyStimulus(3'b000, 6'h0, 6'h0, 6'h0, '0, '0, '0);
   endtask

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   localparam logic [127:0] DA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] DB = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
   localparam logic [127:0] DC = 128'hA5A5_5A5A_1234_5678_9ABC_DEF0_1357_9BDF;
   localparam logic [127:0] DF = {128{1'b1}};

   initial begin
      int first_init;
      idle();
      repeat (3) tick();
      checkOutput("reset_rf_we", rf_we, 0);
      checkOutput("reset_init_done", init_done, 0);
      checkOutput("reset_req_ready", req_ready, 0);
      checkOutput("reset_grant_id", grant_id, 0);
      rst = 1'b0;

`ifdef REGFILE_INIT_SWEEP_EN
      repeat (20) tick();
      checkOutput("sweep_c20_addr", rf_addr, 6'h13);
      rst = 1'b1;
      #1;
      checkOutput("midsweep_rst_we", rf_we, 0);
      checkOutput("midsweep_rst_addr", rf_addr, 0);
      repeat (2) tick();
      rst = 1'b0;
      first_init = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (init_done && first_init == 0) first_init = k;
         if (k == 1) begin
            checkOutput("sweep_c1_we", rf_we, 1);
            checkOutput("sweep_c1_addr", rf_addr, 6'h00);
         end
         if (k == 26) checkOutput("sweep_c26_addr", rf_addr, 6'h20);
         if (k == 50) begin
            checkOutput("sweep_c50_we", rf_we, 1);
            checkOutput("sweep_c50_addr", rf_addr, 6'h38);
         end
         if (k == 51) checkOutput("sweep_c51_we", rf_we, 0);
      end
      checkOutput("sweep_init_cycle", first_init, 51);
`else
      first_init = 0;
      applyStimulus(3'b010, 6'h0, 6'h23, 6'h0, '0, DB, '0);
      #1;
      checkOutput("c0_ready", req_ready, 3'b000);
      tick();
      checkOutput("c1_init_done", init_done, 1);
      checkOutput("c1_ready", req_ready, 3'b010);
      tick();
      idle();
      checkOutput("c2_we", rf_we, 1);
      checkOutput("c2_addr", rf_addr, 6'h23);
      checkOutput("c2_wd", rf_wd, DB);
      checkOutput("c2_gid", grant_id, 1);
      checkOutput("unused_first_init", first_init, 0);
`endif

      // Vector write from requester 2 also leaves the pointer at 0 in both builds.
      applyStimulus(3'b100, 6'h0, 6'h0, 6'h2A, '0, '0, DC);
      tick();
      idle();
      checkOutput("vec_we", rf_we, 1);
      checkOutput("vec_addr", rf_addr, 6'h2A);
      checkOutput("vec_wd", rf_wd, DC);
      checkOutput("vec_gid", grant_id, 2);
      tick();

      applyStimulus(3'b111, 6'h01, 6'h21, 6'h10, DA, DB, DC);
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput("rr_gid", grant_id, 3'(k % 3));
         checkOutput("rr_we", rf_we, 1);
      end
      idle();
      tick();

      applyStimulus(3'b001, 6'h05, 6'h0, 6'h0, DF, '0, '0);
      tick();
      idle();
      checkOutput("scalar_we", rf_we, 1);
      checkOutput("scalar_addr", rf_addr, 6'h05);
      checkOutput("scalar_wd", rf_wd, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
      tick();

      applyStimulus(3'b010, 6'h0, 6'h20, 6'h0, '0, DA, '0);
      tick();
      idle();
      checkOutput("zero_we", rf_we, 0);
      checkOutput("zero_err", addr_err, 0);
      checkOutput("zero_gid", grant_id, 1);
      tick();

      applyStimulus(3'b100, 6'h0, 6'h0, 6'h1B, '0, '0, DB);
      tick();
      idle();
      checkOutput("oor_we", rf_we, 0);
      checkOutput("oor_err", addr_err, 1);
      repeat (3) tick();
      checkOutput("oor_err_sticky", addr_err, 1);

      applyStimulus(3'b101, 6'h02, 6'h0, 6'h03, DA, '0, DC);
      tick();
      checkOutput("cont_gid0", grant_id, 0);
      applyStimulus(3'b100, 6'h02, 6'h0, 6'h03, DA, '0, DC);
      tick();
      idle();
      checkOutput("cont_gid2", grant_id, 2);
      checkOutput("cont_wd2", rf_wd, 128'h0000_0000_0000_0000_0000_0000_1357_9BDF);
      tick();

      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'b010, 6'h0, 6'(6'h24 + k), 6'h0, '0, DA ^ 128'(k), '0);
         tick();
         checkOutput("stream_we", rf_we, 1);
         checkOutput("stream_addr", rf_addr, 6'(6'h24 + k));
      end
      idle();
      tick();

      rst = 1'b1;
      #1;
      checkOutput("final_rst_err", addr_err, 0);
      checkOutput("final_rst_gid", grant_id, 0);
      checkOutput("final_rst_ready", req_ready, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
